// File: rtl/slc3_input_pkg.sv
// Shared types and sizing helpers for the SLC-3 input conditioner.
package slc3_input_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      HELD,
      REPEAT,
      DISARM
   } btn_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY    = 8;
   localparam int DEF_REPEAT_PERIOD   = 3;

   function automatic int cnt_width(input int max_count);
      int w;
      w = $clog2(max_count + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/slc3_input_conditioner_btn_debounce.sv
// One active-low button channel: 2-flop synchroniser, debounce/repeat FSM.
//
//   state  | meaning
//   IDLE   | released, waiting for a press
//   ARM    | press seen, counting stable pressed cycles
//   HELD   | press accepted, counting towards first repeat
//   REPEAT | auto-repeat running, one press pulse per period
//   DISARM | release seen, counting stable released cycles
module slc3_btn_debounce
   import slc3_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic Clk,
   input  logic Reset,
   input  logic btn_n,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CW      = cnt_width(MAX_CNT);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic          sync1, sync2;
   logic          p;
   btn_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_d, press_d, release_d;

   // Synchronisers reset to released so no press is seen coming out of reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   assign p = ~sync2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         level         <= level_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (p) begin
               state_d = ARM;
               cnt_d   = '0;
            end
         end
         ARM: begin
            if (!p) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (!p) begin
               state_d = DISARM;
               cnt_d   = '0;
            end else if (REPEAT_EN && (cnt_q == DLY_LAST)) begin
               state_d = REPEAT;
               cnt_d   = '0;
               press_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         REPEAT: begin
            if (!p) begin
               state_d = DISARM;
               cnt_d   = '0;
            end else if (cnt_q == PER_LAST) begin
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DISARM: begin
            if (p) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/slc3_input_conditioner.sv
// SLC-3 board input front end: per-button debounce channels plus switch sync.
module slc3_input_conditioner
   import slc3_input_pkg::*;
#(
   parameter int NUM_BTN         = 2,
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [NUM_BTN-1:0]  btn_n,
   input  logic [SW_WIDTH-1:0] sw_raw,
   output logic [NUM_BTN-1:0]  btn_level,
   output logic [NUM_BTN-1:0]  btn_press,
   output logic [NUM_BTN-1:0]  btn_release,
   output logic [SW_WIDTH-1:0] sw_sync,
   output logic                sw_changed
);

   logic [SW_WIDTH-1:0] sw_meta;
   logic [SW_WIDTH-1:0] sw_prev;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      slc3_btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_btn (
         .Clk           (Clk),
         .Reset         (Reset),
         .btn_n         (btn_n[i]),
         .level         (btn_level[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i])
      );
   end

   // Switches are level inputs: synchronise only, flag any change for one cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sw_meta    <= '0;
         sw_sync    <= '0;
         sw_prev    <= '0;
         sw_changed <= 1'b0;
      end else begin
         sw_meta    <= sw_raw;
         sw_sync    <= sw_meta;
         sw_prev    <= sw_sync;
         sw_changed <= (sw_sync != sw_prev);
      end
   end

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Directed bench for slc3_input_conditioner: one plain and one auto-repeat instance.
module tb_slc3_input_conditioner;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  btn_n;
   logic [1:0]  rbtn_n;
   logic [15:0] sw_raw;

   logic [1:0]  btn_level, btn_press, btn_release;
   logic [15:0] sw_sync;
   logic        sw_changed;
   logic [1:0]  r_level, r_press, r_release;
   logic [15:0] r_sw_sync;
   logic        r_sw_changed;

   int tests = 0;
   int fails = 0;
   int cnt;

   always #5 Clk = ~Clk;

   slc3_input_conditioner #(
      .NUM_BTN(2), .SW_WIDTH(16), .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
   ) dut (
      .Clk(Clk), .Reset(Reset), .btn_n(btn_n), .sw_raw(sw_raw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .sw_sync(sw_sync), .sw_changed(sw_changed)
   );

   slc3_input_conditioner #(
      .NUM_BTN(2), .SW_WIDTH(16), .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
   ) dut_rep (
      .Clk(Clk), .Reset(Reset), .btn_n(rbtn_n), .sw_raw(sw_raw),
      .btn_level(r_level), .btn_press(r_press), .btn_release(r_release),
      .sw_sync(r_sw_sync), .sw_changed(r_sw_changed)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset  = 1'b1;
      btn_n  = 2'b11;
      rbtn_n = 2'b11;
      sw_raw = 16'h0003;

      // Reset state
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_level", btn_level, 2'b00);
         chk("rst_press", btn_press, 2'b00);
         chk("rst_release", btn_release, 2'b00);
         chk("rst_sw_sync", sw_sync, 16'h0000);
         chk("rst_sw_changed", sw_changed, 1'b0);
      end
      Reset = 1'b0;
      tick();
      chk("post_rst_sw_sync1", sw_sync, 16'h0000);
      tick();
      chk("post_rst_sw_sync2", sw_sync, 16'h0003);
      chk("post_rst_sw_chg2", sw_changed, 1'b0);
      tick();
      chk("post_rst_sw_chg3", sw_changed, 1'b1);
      tick();
      chk("post_rst_sw_chg4", sw_changed, 1'b0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (btn_press != 2'b00 || btn_release != 2'b00 || r_press != 2'b00) cnt++;
      end
      chk("post_rst_no_btn_pulse", cnt, 0);

      // Clean press on channel 0: press 6 edges after first low sample
      btn_n[0] = 1'b0;
      for (int t = 1; t <= 6; t++) begin
         tick();
         chk("press_wait", btn_press[0], 1'b0);
         chk("press_wait_level", btn_level[0], 1'b0);
      end
      tick();
      chk("press_pulse", btn_press, 2'b01);
      chk("press_level", btn_level, 2'b01);
      tick();
      chk("press_pulse_end", btn_press[0], 1'b0);
      chk("press_level_hold", btn_level[0], 1'b1);
      cnt = 0;
      for (int t = 9; t <= 20; t++) begin
         tick();
         if (btn_press[0]) cnt++;
      end
      chk("no_repeat_when_disabled", cnt, 0);
      chk("level_still_held", btn_level[0], 1'b1);

      btn_n[0] = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         chk("release_wait", btn_release[0], 1'b0);
         chk("release_wait_level", btn_level[0], 1'b1);
      end
      tick();
      chk("release_pulse", btn_release, 2'b01);
      chk("release_level", btn_level[0], 1'b0);
      tick();
      chk("release_pulse_end", btn_release[0], 1'b0);

      // Press bounce on channel 1: 3 low cycles are rejected
      btn_n[1] = 1'b0;
      tick(); tick(); tick();
      btn_n[1] = 1'b1;
      cnt = 0;
      for (int t = 0; t < 12; t++) begin
         tick();
         if (btn_press[1] || btn_level[1] || btn_release[1]) cnt++;
      end
      chk("bounce_rejected", cnt, 0);

      // Release glitch on channel 1 while HELD
      btn_n[1] = 1'b0;
      for (int t = 0; t < 10; t++) tick();
      chk("glitch_held_level", btn_level[1], 1'b1);
      btn_n[1] = 1'b1;
      tick(); tick();
      btn_n[1] = 1'b0;
      cnt = 0;
      for (int t = 0; t < 12; t++) begin
         tick();
         if (btn_release[1] || !btn_level[1] || btn_press[1]) cnt++;
      end
      chk("glitch_rejected", cnt, 0);
      btn_n[1] = 1'b1;
      cnt = 0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (btn_release[1]) cnt++;
      end
      chk("glitch_final_release_count", cnt, 1);
      chk("glitch_final_level", btn_level[1], 1'b0);

      // Auto-repeat on the repeat instance: pulses at ticks 7,15,18,21,...
      rbtn_n[0] = 1'b0;
      for (int t = 1; t <= 30; t++) begin
         tick();
         chk("repeat_pulse", r_press[0], (t == 7 || t == 15 || t == 18 || t == 21 ||
                                          t == 24 || t == 27 || t == 30) ? 1'b1 : 1'b0);
      end
      chk("repeat_level", r_level[0], 1'b1);
      rbtn_n[0] = 1'b1;
      cnt = 0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (r_press[0]) cnt++;
         if (t == 7) chk("repeat_release_pulse", r_release[0], 1'b1);
      end
      chk("repeat_stops_on_release", cnt, 0);
      chk("repeat_release_level", r_level[0], 1'b0);

      // Switch change
      sw_raw = 16'h0005;
      tick();
      chk("sw_sync_lag", sw_sync, 16'h0003);
      tick();
      chk("sw_sync_new", sw_sync, 16'h0005);
      cnt = 0;
      for (int t = 0; t < 6; t++) begin
         tick();
         if (sw_changed) cnt++;
      end
      chk("sw_changed_once", cnt, 1);

      // Reset while HELD, button kept pressed through reset
      btn_n[0] = 1'b0;
      for (int t = 0; t < 10; t++) tick();
      chk("pre_reset_held", btn_level[0], 1'b1);
      Reset = 1'b1;
      tick();
      chk("reset_held_level", btn_level[0], 1'b0);
      chk("reset_held_release", btn_release[0], 1'b0);
      Reset = 1'b0;
      cnt = 0;
      for (int t = 1; t <= 6; t++) begin
         tick();
         if (btn_press[0] || btn_release[0] || btn_level[0]) cnt++;
      end
      chk("after_reset_quiet", cnt, 0);
      tick();
      chk("after_reset_repress", btn_press[0], 1'b1);
      chk("after_reset_level", btn_level[0], 1'b1);
      btn_n[0] = 1'b1;
      for (int t = 0; t < 10; t++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
